// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types, mode constants and select-width helper for scan_mux_seq
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MANUAL,
        SCAN
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int sel_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - combinational index to one-hot decoder with enable
module onehot_dec #(
    parameter int N    = 8,
    parameter int SELW = 3
) (
    input  logic [SELW-1:0] idx,
    input  logic            en,
    output logic [N-1:0]    onehot
);

    // Compare against each position so out-of-range indices simply decode to zero
    always_comb begin
        onehot = '0;
        for (int k = 0; k < N; k++) begin
            onehot[k] = en && (idx == SELW'(k));
        end
    end

endmodule

// File: rtl/scan_mux_seq.sv
// rtl/scan_mux_seq.sv - registered N-channel mux with manual select and auto-scan modes
module scan_mux_seq
    import scan_pkg::*;
#(
    parameter  int N_CH  = 8,
    parameter  int W     = 1,
    parameter  int DWELL = 4,
    localparam int SELW  = sel_width(N_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_mode,
    input  logic [SELW-1:0]   i_sel,
    input  logic [N_CH*W-1:0] i_data,
    output logic [W-1:0]      o_data,
    output logic [SELW-1:0]   o_ch,
    output logic [N_CH-1:0]   o_onehot,
    output logic              o_valid,
    output logic              o_wrap,
    output logic              o_err
);

    localparam int              CNTW    = $clog2(DWELL + 1);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DWELL);
    localparam logic [SELW-1:0] LAST_CH = SELW'(N_CH - 1);

    state_t          state, state_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic [SELW-1:0] ch_nxt;
    logic [W-1:0]    data_nxt;
    logic            valid_nxt, wrap_nxt, err_nxt;
    logic [N_CH-1:0] onehot_nxt;
    logic [W-1:0]    chans [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign chans[k] = i_data[k*W +: W];
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ch_nxt    = o_ch;
        data_nxt  = o_data;
        valid_nxt = 1'b0;
        wrap_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (i_en) begin
            if (i_mode == MODE_SCAN) begin
                state_nxt = SCAN;
                valid_nxt = 1'b1;
                // Entering scan keeps the current channel and starts its dwell afresh
                if (state != SCAN) begin
                    cnt_nxt = CNT_ONE;
                end else if (cnt == CNT_MAX) begin
                    cnt_nxt = CNT_ONE;
                    if (o_ch == LAST_CH) begin
                        ch_nxt   = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        ch_nxt = o_ch + SELW'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end else begin
                state_nxt = MANUAL;
                cnt_nxt   = '0;
                if (int'(i_sel) < N_CH) begin
                    ch_nxt    = i_sel;
                    valid_nxt = 1'b1;
                end else begin
                    err_nxt = 1'b1;
                end
            end
            if (valid_nxt) begin
                data_nxt = chans[ch_nxt];
            end
        end
    end

    onehot_dec #(
        .N    (N_CH),
        .SELW (SELW)
    ) u_dec (
        .idx    (ch_nxt),
        .en     (valid_nxt),
        .onehot (onehot_nxt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            o_ch     <= '0;
            o_data   <= '0;
            o_onehot <= '0;
            o_valid  <= 1'b0;
            o_wrap   <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            o_ch     <= ch_nxt;
            o_data   <= data_nxt;
            o_onehot <= onehot_nxt;
            o_valid  <= valid_nxt;
            o_wrap   <= wrap_nxt;
            o_err    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_scan_mux_seq.sv
// tb/tb_scan_mux_seq.sv - scoreboard bench for scan_mux_seq (4-channel and 5-channel instances)
module tb_scan_mux_seq;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] ch;
        logic [4:0] onehot;
        logic       valid;
        logic       wrap;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        mode = 1'b0;
    logic [2:0]  sel = '0;
    logic [39:0] data = '0;

    logic [7:0] o_data_a, o_data_b;
    logic [1:0] o_ch_a;
    logic [2:0] o_ch_b;
    logic [3:0] o_onehot_a;
    logic [4:0] o_onehot_b;
    logic       o_valid_a, o_wrap_a, o_err_a;
    logic       o_valid_b, o_wrap_b, o_err_b;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    int         m_state [2];
    int         m_ch    [2];
    int         m_dw    [2];
    logic [7:0] m_data  [2];

    always #5 clk = ~clk;

    scan_mux_seq #(.N_CH(4), .W(8), .DWELL(2)) dut_a (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_en     (en),
        .i_mode   (mode),
        .i_sel    (sel[1:0]),
        .i_data   (data[31:0]),
        .o_data   (o_data_a),
        .o_ch     (o_ch_a),
        .o_onehot (o_onehot_a),
        .o_valid  (o_valid_a),
        .o_wrap   (o_wrap_a),
        .o_err    (o_err_a)
    );

    scan_mux_seq #(.N_CH(5), .W(8), .DWELL(3)) dut_b (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_en     (en),
        .i_mode   (mode),
        .i_sel    (sel),
        .i_data   (data),
        .o_data   (o_data_b),
        .o_ch     (o_ch_b),
        .o_onehot (o_onehot_b),
        .o_valid  (o_valid_b),
        .o_wrap   (o_wrap_b),
        .o_err    (o_err_b)
    );

    function automatic exp_t got_a();
        return {o_data_a, 1'b0, o_ch_a, 1'b0, o_onehot_a, o_valid_a, o_wrap_a, o_err_a};
    endfunction

    function automatic exp_t got_b();
        return {o_data_b, o_ch_b, o_onehot_b, o_valid_b, o_wrap_b, o_err_b};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int id = 0; id < 2; id++) begin
            m_state[id] = 0;
            m_ch[id]    = 0;
            m_dw[id]    = 0;
            m_data[id]  = '0;
        end
    endtask

    // Behavioural view: a channel is shown for `dwell` enabled scan cycles, then the next one modulo n
    task automatic model_step(input int id, input bit e, input bit md, input logic [2:0] s_in,
                              input logic [39:0] d, output exp_t x);
        int n, dwell, s;
        n     = (id == 0) ? 4 : 5;
        dwell = (id == 0) ? 2 : 3;
        s     = (id == 0) ? int'(s_in[1:0]) : int'(s_in);
        x = '0;
        if (e) begin
            if (!md) begin
                m_state[id] = 1;
                m_dw[id]    = 0;
                if (s < n) begin
                    m_ch[id]   = s;
                    m_data[id] = d[s*8 +: 8];
                    x.valid    = 1'b1;
                end else begin
                    x.err = 1'b1;
                end
            end else begin
                if (m_state[id] != 2) begin
                    m_dw[id] = 1;
                end else if (m_dw[id] == dwell) begin
                    m_ch[id] = (m_ch[id] + 1) % n;
                    m_dw[id] = 1;
                    x.wrap   = (m_ch[id] == 0);
                end else begin
                    m_dw[id]++;
                end
                m_state[id] = 2;
                m_data[id]  = d[m_ch[id]*8 +: 8];
                x.valid     = 1'b1;
            end
        end
        x.ch   = 3'(m_ch[id]);
        x.data = m_data[id];
        if (x.valid) x.onehot = 5'(1 << m_ch[id]);
    endtask

    task automatic step(input bit r, input bit e, input bit md, input logic [2:0] s, input logic [39:0] d);
        exp_t xa, xb;
        @(negedge clk);
        rst_n = r;
        en    = e;
        mode  = md;
        sel   = s;
        data  = d;
        if (!r) begin
            model_reset();
            q_a.push_back('0);
            q_b.push_back('0);
            #1;
            check("async_reset_a", 64'(got_a()), 64'(0));
            check("async_reset_b", 64'(got_b()), 64'(0));
        end else begin
            model_step(0, e, md, s, d, xa);
            model_step(1, e, md, s, d, xb);
            q_a.push_back(xa);
            q_b.push_back(xb);
        end
    endtask

    // Monitor: one expected response per edge per instance
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                x = q_a.pop_front();
                check("out_a", 64'(got_a()), 64'(x));
            end else if (o_valid_a || o_wrap_a || o_err_a) begin
                check("unexpected_a", 64'(got_a()), 64'(0));
            end
            if (q_b.size() > 0) begin
                x = q_b.pop_front();
                check("out_b", 64'(got_b()), 64'(x));
            end else if (o_valid_b || o_wrap_b || o_err_b) begin
                check("unexpected_b", 64'(got_b()), 64'(0));
            end
        end
    end

    initial begin
        logic [39:0] pat;
        int          scan_ch [9];
        logic [7:0]  scan_dt [9];
        bit          r_mode, r_en, r_rst;
        logic [2:0]  r_sel;
        logic [39:0] r_data;

        pat     = 40'hE4_D3_C2_B1_A0;
        scan_ch = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        scan_dt = '{8'hA0, 8'hA0, 8'hB1, 8'hB1, 8'hC2, 8'hC2, 8'hD3, 8'hD3, 8'hA0};
        model_reset();

        #2;
        check("reset_a", 64'(got_a()), 64'(0));
        check("reset_b", 64'(got_b()), 64'(0));
        step(0, 0, 0, 0, pat);
        step(0, 0, 0, 0, pat);

        // Scan sweep from reset on the 4-channel, DWELL=2 instance
        for (int i = 0; i < 9; i++) begin
            step(1, 1, 1, 0, pat);
            @(posedge clk);
            #2;
            check("sweep_ch",   64'(o_ch_a),   64'(scan_ch[i]));
            check("sweep_data", 64'(o_data_a), 64'(scan_dt[i]));
            check("sweep_wrap", 64'(o_wrap_a), 64'(i == 8));
        end

        // Manual select, then an out-of-range select on the 5-channel instance
        step(1, 1, 0, 3'd2, pat);
        step(1, 1, 0, 3'd2, pat);
        step(1, 1, 0, 3'd0, pat);
        step(1, 1, 0, 3'd3, pat);
        step(1, 1, 0, 3'd6, pat);
        step(1, 1, 0, 3'd7, pat);

        // Freeze mid-dwell then resume
        step(0, 0, 0, 0, pat);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, pat);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, pat);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, pat);

        // Scan to manual and back
        step(1, 1, 0, 3'd0, pat);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, pat);

        // Asynchronous reset mid-scan, then restart
        step(0, 1, 1, 0, pat);
        for (int i = 0; i < 6; i++) step(1, 1, 1, 0, pat);

        r_mode = 1'b1;
        r_data = pat;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 24) == 0) r_mode = ~r_mode;
            r_en  = ($urandom_range(0, 7) != 0);
            r_rst = ($urandom_range(0, 249) != 0);
            r_sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) r_data = 40'({$urandom(), $urandom()});
            step(r_rst, r_en, r_mode, r_sel, r_data);
        end

        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, r_data);
        @(posedge clk);
        #3;
        check("drain_a", 64'(q_a.size()), 64'(0));
        check("drain_b", 64'(q_b.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_mux_seq.md
Name: scan_mux_seq

Overview:
- Parametrised, registered N-channel, W-bit multiplexer with an integrated one-hot channel decoder.
- Generalises the combinational 2:1/4:1/8:1 mux and 2:4/3:8 decoder family to arbitrary channel count and width.
- Adds a manual-select mode and an auto-scan mode that sweeps through the channels with a programmable dwell time.
- Sits between parallel sources (switch banks, sensor lines) and a single shared consumer such as a display or shared bus.

Parameters:
N_CH, 8, number of input channels (>=2, need not be a power of 2)
W, 1, bits per channel
DWELL, 4, clock cycles each channel is held in scan mode (>=1)
SELW, max(1,$clog2(N_CH)), derived select width (localparam, not overridable)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_en  input  1  enable; 0 freezes all state
i_mode  input  1  0 = manual select, 1 = auto-scan
i_sel  input  SELW  manual channel select
i_data  input  N_CH*W  packed channels; channel k = i_data[k*W +: W]
o_data  output  W  registered selected channel data
o_ch  output  SELW  registered index of the channel currently in o_data
o_onehot  output  N_CH  registered one-hot of o_ch; all-zero when o_valid=0
o_valid  output  1  o_data/o_ch valid this cycle
o_wrap  output  1  one-cycle pulse, scan wrapped from N_CH-1 to 0
o_err  output  1  one-cycle pulse, manual i_sel >= N_CH

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (i_clk, i_rst_n).
- Reset values: o_data=0, o_ch=0, o_onehot=0, o_valid=0, o_wrap=0, o_err=0. Internal state=IDLE, dwell count cnt=0.
- Reset asserted mid-operation clears everything immediately and asynchronously. After release, the block behaves as from power-up.
- Latency: every output is registered. The value on i_data/i_sel sampled at edge n appears after edge n.
- States:
  - IDLE: after reset, before the first enabled cycle.
  - MANUAL: manual select active.
  - SCAN: auto-scan active.
- Transitions, taken only on an edge with i_en=1:
  - Any state goes to MANUAL if i_mode=0.
  - Any state goes to SCAN if i_mode=1.
- i_en=0 in any state:
  - state, o_ch, cnt and o_data hold;
  - o_valid=0, o_onehot=0, o_wrap=0, o_err=0;
  - SCAN resumes from the frozen o_ch/cnt with no re-entry.
- MANUAL, enabled, i_sel<N_CH:
  - o_ch<=i_sel, o_data<=channel i_sel;
  - o_valid=1, o_onehot=decode(i_sel).
- MANUAL, enabled, i_sel>=N_CH (only possible when N_CH is not a power of 2):
  - o_ch and o_data hold;
  - o_valid=0, o_onehot=0, o_err=1 for that cycle.
- SCAN entry (previous state IDLE or MANUAL): o_ch holds, cnt<=1, o_data<=channel o_ch, o_valid=1.
- SCAN steady, enabled:
  - if cnt==DWELL: o_ch<=(o_ch==N_CH-1)?0:o_ch+1, cnt<=1;
  - otherwise: cnt<=cnt+1 and o_ch holds.
  - o_data always tracks the next o_ch value, so o_data and o_ch are always consistent.
- o_wrap=1 on exactly the edge where o_ch goes from N_CH-1 to 0 in SCAN.
- DWELL=1 advances the channel every enabled cycle.
- Data is re-sampled every enabled cycle. A source change during a dwell is visible on the next cycle.
- Mode switch from SCAN to MANUAL takes effect on the same edge: i_sel is used and cnt is cleared to 0.
- cnt width is $clog2(DWELL+1). The counter never exceeds DWELL.

Decomposition:
- Shared package scan_pkg:
  - state enum {IDLE, MANUAL, SCAN};
  - function sel_width(n) returning max(1,$clog2(n));
  - MODE_MANUAL/MODE_SCAN constants.
- Sub-module onehot_dec (parametrised N, SELW; combinational; input index plus enable, output N-bit one-hot) drives the o_onehot register input.

Test Plan:
- N_CH=4, W=8, DWELL=2, i_data={8'hD3,8'hC2,8'hB1,8'hA0}; reset, then i_en=1, i_mode=1 -> o_ch over successive edges 0,0,1,1,2,2,3,3,0; o_data A0,A0,B1,B1,C2,C2,D3,D3,A0; o_wrap=1 only on the 9th edge; o_onehot 0001,...,1000.
- Same config, i_mode=0, i_sel=2 -> one edge later o_ch=2, o_data=8'hC2, o_onehot=4'b0100, o_valid=1; change i_sel to 0 -> A0 next cycle.
- N_CH=5, i_mode=0, i_sel=6 after i_sel=3 -> o_err=1, o_valid=0, o_onehot=0, o_ch stays 3, o_data holds channel 3.
- Scan at o_ch=1 with cnt=1, drop i_en for 3 cycles -> o_valid=0, o_ch=1 frozen; re-enable -> one more cycle at ch1, then ch2 (no re-entry reset of cnt).
- Scan mid-sweep at o_ch=2, then i_mode=0, i_sel=0 -> next edge o_ch=0; return to i_mode=1 -> ch0 held DWELL cycles, then ch1.
- Pulse i_rst_n low asynchronously between edges during scan -> all outputs 0 immediately; after release plus an enabled edge, the sequence restarts at ch0 from IDLE.
